// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot point iterator.
//   - Default coordinate / iteration-counter widths.
//   - Controller state encoding.
//   - Fixed-point constants for the default 2.(WIDTH-2) format.
//   - fx_four_sq(): the value 4.0 expressed at product scale (2*(width-2) fraction bits),
//     used as the |z|^2 escape radius.
package mandelbrot_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_ITER_WIDTH = 6;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   localparam logic [DEF_WIDTH-1:0] ONE       = DEF_WIDTH'(1 << (DEF_WIDTH - 2));
   localparam logic [DEF_WIDTH-1:0] MINUS_TWO = DEF_WIDTH'(-(2 << (DEF_WIDTH - 2)));

   function automatic int fx_four_sq(input int width);
      return 4 << (2 * (width - 2));
   endfunction

endpackage

// File: rtl/mandelbrot_iterator_if.sv
// Handshake bundle between the coordinate generator, the iterator and the colour stage.
//   Request : in_valid, in_ready, in_cr, in_ci, in_max_iter
//   Result  : out_valid, out_ready, out_iter, out_escaped
// Modports: master = point source / result sink, slave = iterator.
interface mandelbrot_iterator_if
   import mandelbrot_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ITER_WIDTH = DEF_ITER_WIDTH
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      in_cr;
   logic [WIDTH-1:0]      in_ci;
   logic [ITER_WIDTH-1:0] in_max_iter;
   logic                  out_valid;
   logic                  out_ready;
   logic [ITER_WIDTH-1:0] out_iter;
   logic                  out_escaped;

   modport master (
      output in_valid, in_cr, in_ci, in_max_iter, out_ready,
      input  in_ready, out_valid, out_iter, out_escaped
   );

   modport slave (
      input  in_valid, in_cr, in_ci, in_max_iter, out_ready,
      output in_ready, out_valid, out_iter, out_escaped
   );

endinterface

// File: rtl/mandelbrot_alu.sv
// Combinational Mandelbrot step: (out_zr, out_zi) = z^2 + c in signed 2.(WIDTH-2).
// Ports:
//   cr, ci, zr, zi   in  WIDTH  c and current z
//   out_zr, out_zi   out WIDTH  next z (truncated to WIDTH)
//   size             out 1      |z|^2 > 4 for the current z
//   overflow         out 1      next z does not fit in WIDTH bits
module mandelbrot_alu
   import mandelbrot_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic signed [WIDTH-1:0] cr,
   input  logic signed [WIDTH-1:0] ci,
   input  logic signed [WIDTH-1:0] zr,
   input  logic signed [WIDTH-1:0] zi,
   output logic signed [WIDTH-1:0] out_zr,
   output logic signed [WIDTH-1:0] out_zi,
   output logic                    size,
   output logic                    overflow
);

   // Wide enough for squares, their sum and the doubled cross term without loss.
   localparam int PW = 2 * WIDTH + 2;
   localparam logic signed [PW-1:0] FOUR = PW'(fx_four_sq(WIDTH));

   logic signed [PW-1:0] zr_w, zi_w, cr_w, ci_w;
   logic signed [PW-1:0] zr2, zi2, zrzi, re_full, im_full, mag;
   logic                 re_fits, im_fits;

   assign zr_w = {{(PW - WIDTH){zr[WIDTH-1]}}, zr};
   assign zi_w = {{(PW - WIDTH){zi[WIDTH-1]}}, zi};
   assign cr_w = {{(PW - WIDTH){cr[WIDTH-1]}}, cr};
   assign ci_w = {{(PW - WIDTH){ci[WIDTH-1]}}, ci};

   assign zr2  = zr_w * zr_w;
   assign zi2  = zi_w * zi_w;
   assign zrzi = zr_w * zi_w;

   // Products carry 2*(WIDTH-2) fraction bits; arithmetic shift rescales (floor).
   assign re_full = ((zr2 - zi2) >>> (WIDTH - 2)) + cr_w;
   assign im_full = ((zrzi <<< 1) >>> (WIDTH - 2)) + ci_w;
   assign mag     = zr2 + zi2;

   // In range when every bit above the WIDTH-bit sign equals that sign.
   assign re_fits = (&re_full[PW-1:WIDTH-1]) | ~(|re_full[PW-1:WIDTH-1]);
   assign im_fits = (&im_full[PW-1:WIDTH-1]) | ~(|im_full[PW-1:WIDTH-1]);

   assign out_zr   = re_full[WIDTH-1:0];
   assign out_zi   = im_full[WIDTH-1:0];
   assign size     = mag > FOUR;
   assign overflow = ~(re_fits & im_fits);

endmodule

// File: rtl/mandelbrot_iterator.sv
// Iteration controller for one Mandelbrot point: accepts c, iterates z <- z^2 + c from 0
// until escape (size/overflow) or the iteration limit, then presents the result.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   bus   mandelbrot_iterator_if.slave (request and result handshakes)
// Build option: define MANDEL_PIPE_EN to register the ALU outputs, making each step two
// cycles (calc, then update). Results are identical in both builds.
module mandelbrot_iterator
   import mandelbrot_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ITER_WIDTH = DEF_ITER_WIDTH
) (
   input logic                 clk,
   input logic                 rst,
   mandelbrot_iterator_if.slave bus
);

   state_e                  state;
   logic signed [WIDTH-1:0] cr, ci, zr, zi;
   logic [ITER_WIDTH-1:0]   max_iter, iter, iter_inc;
   logic                    in_ready_q, out_valid_q, out_escaped_q;
   logic [ITER_WIDTH-1:0]   out_iter_q;

   logic signed [WIDTH-1:0] alu_zr, alu_zi;
   logic                    alu_size, alu_ovf;
   logic signed [WIDTH-1:0] step_zr, step_zi;
   logic                    step_esc, do_step;

   mandelbrot_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .cr       (cr),
      .ci       (ci),
      .zr       (zr),
      .zi       (zi),
      .out_zr   (alu_zr),
      .out_zi   (alu_zi),
      .size     (alu_size),
      .overflow (alu_ovf)
   );

`ifdef MANDEL_PIPE_EN
   logic                    calc_q;
   logic signed [WIDTH-1:0] pipe_zr, pipe_zi;
   logic                    pipe_esc;

   assign step_zr  = pipe_zr;
   assign step_zi  = pipe_zi;
   assign step_esc = pipe_esc;
   assign do_step  = (state == StRun) && !calc_q;

   // Calc cycles capture the ALU; update cycles consume the capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         calc_q   <= 1'b0;
         pipe_zr  <= '0;
         pipe_zi  <= '0;
         pipe_esc <= 1'b0;
      end else if (state == StIdle) begin
         calc_q <= 1'b1;
      end else if (state == StRun) begin
         calc_q <= ~calc_q;
         if (calc_q) begin
            pipe_zr  <= alu_zr;
            pipe_zi  <= alu_zi;
            pipe_esc <= alu_size | alu_ovf;
         end
      end
   end
`else
   assign step_zr  = alu_zr;
   assign step_zi  = alu_zi;
   assign step_esc = alu_size | alu_ovf;
   assign do_step  = (state == StRun);
`endif

   // Cannot wrap: iter < max_iter <= 2^ITER_WIDTH-1 whenever a step is applied.
   assign iter_inc = iter + ITER_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= StIdle;
         cr            <= '0;
         ci            <= '0;
         zr            <= '0;
         zi            <= '0;
         max_iter      <= '0;
         iter          <= '0;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
         out_iter_q    <= '0;
         out_escaped_q <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (bus.in_valid) begin
                  cr         <= bus.in_cr;
                  ci         <= bus.in_ci;
                  max_iter   <= bus.in_max_iter;
                  zr         <= '0;
                  zi         <= '0;
                  iter       <= '0;
                  in_ready_q <= 1'b0;
                  if (bus.in_max_iter == '0) begin
                     out_iter_q    <= '0;
                     out_escaped_q <= 1'b0;
                     out_valid_q   <= 1'b1;
                     state         <= StDone;
                  end else begin
                     state <= StRun;
                  end
               end
            end
            StRun: begin
               if (do_step) begin
                  if (step_esc) begin
                     // Escape wins over the limit; z keeps its last in-bounds value.
                     out_iter_q    <= iter;
                     out_escaped_q <= 1'b1;
                     out_valid_q   <= 1'b1;
                     state         <= StDone;
                  end else begin
                     zr   <= step_zr;
                     zi   <= step_zi;
                     iter <= iter_inc;
                     if (iter_inc == max_iter) begin
                        out_iter_q    <= max_iter;
                        out_escaped_q <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state         <= StDone;
                     end
                  end
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_iter    = out_iter_q;
   assign bus.out_escaped = out_escaped_q;

endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Self-checking bench for mandelbrot_iterator (WIDTH=8, ITER_WIDTH=6).
// A per-cycle monitor compares the DUT against an integer escape-time model; directed
// points additionally pin literal results and latencies. Honours MANDEL_PIPE_EN.
module tb_mandelbrot_iterator;
   import mandelbrot_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mandelbrot_iterator_if #(.WIDTH(8), .ITER_WIDTH(6)) bus ();

   mandelbrot_iterator #(
      .WIDTH      (8),
      .ITER_WIDTH (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Escape-time model: k is the number of steps evaluated.
   task automatic model(input logic [7:0] cr8, input logic [7:0] ci8, input int mx,
                        output int iter, output int esc, output int k);
      int cr, ci, zr, zi, nzr, nzi;
      cr = $signed(cr8);
      ci = $signed(ci8);
      zr = 0;
      zi = 0;
      iter = mx;
      esc = 0;
      k = mx;
      for (int s = 1; s <= mx; s++) begin
         nzr = ((zr * zr - zi * zi) >>> 6) + cr;
         nzi = ((2 * zr * zi) >>> 6) + ci;
         if ((zr * zr + zi * zi > 4 * 64 * 64) || nzr > 127 || nzr < -128 ||
             nzi > 127 || nzi < -128) begin
            iter = s - 1;
            esc = 1;
            k = s;
            return;
         end
         zr = nzr;
         zi = nzi;
      end
   endtask

   function automatic int lat_of(input int k);
      if (k == 0) return 1;
`ifdef MANDEL_PIPE_EN
      return 2 * k + 1;
`else
      return k + 1;
`endif
   endfunction

   // Monitor state
   bit pending = 0, post_rst = 0, ready_next = 0, armed = 0;
   int m_iter, m_esc, m_k, m_lat, cnt;

   always @(negedge clk) begin
      if (rst) begin
         pending = 0;
         post_rst = 1;
         ready_next = 0;
         armed = 1;
      end else if (armed) begin
         if (post_rst) begin
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_in_ready", bus.in_ready, 1);
            check("rst_out_iter", bus.out_iter, 0);
            check("rst_out_escaped", bus.out_escaped, 0);
            post_rst = 0;
         end
         if (pending) begin
            cnt++;
            check("mon_out_valid_timing", bus.out_valid, (cnt >= m_lat) ? 1 : 0);
            check("mon_in_ready_busy", bus.in_ready, 0);
            if (bus.out_valid === 1'b1) begin
               check("mon_out_iter", bus.out_iter, m_iter);
               check("mon_out_escaped", bus.out_escaped, m_esc);
               if (bus.out_ready === 1'b1) begin
                  pending = 0;
                  ready_next = 1;
               end
            end
         end else begin
            check("mon_idle_out_valid", bus.out_valid, 0);
            if (ready_next) check("mon_in_ready_resume", bus.in_ready, 1);
            ready_next = 0;
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
               model(bus.in_cr, bus.in_ci, int'(bus.in_max_iter), m_iter, m_esc, m_k);
               m_lat = lat_of(m_k);
               cnt = 0;
               pending = 1;
            end
         end
      end
   end

   task automatic run_point(input logic [7:0] cr, input logic [7:0] ci, input logic [5:0] mx,
                            input bit lit, input int e_iter, input int e_esc, input int e_k,
                            input int hold);
      int n, d;
      bus.in_cr = cr;
      bus.in_ci = ci;
      bus.in_max_iter = mx;
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_cr = 8'($urandom);
      bus.in_ci = 8'($urandom);
      bus.in_max_iter = 6'($urandom);
      d = 1;
      while (bus.out_valid !== 1'b1 && d < 400) begin
         @(posedge clk); #1; d++;
      end
      if (bus.out_valid !== 1'b1) begin
         checks++; errors++;
         $display("FAIL result_timeout actual=no_out_valid required=out_valid");
      end else if (lit) begin
         check("lit_latency", d, lat_of(e_k));
         check("lit_out_iter", bus.out_iter, e_iter);
         check("lit_out_escaped", bus.out_escaped, e_esc);
      end
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = (i % 2 == 0);
         bus.in_cr = 8'($urandom);
         bus.in_max_iter = 6'($urandom);
         @(posedge clk); #1;
         check("hold_out_valid", bus.out_valid, 1);
         check("hold_in_ready", bus.in_ready, 0);
         if (lit) begin
            check("hold_out_iter", bus.out_iter, e_iter);
            check("hold_out_escaped", bus.out_escaped, e_esc);
         end
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   logic [7:0] neg_one;

   initial begin
      neg_one = 8'(-ONE);
      bus.in_valid = 1'b0;
      bus.in_cr = '0;
      bus.in_ci = '0;
      bus.in_max_iter = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_point(8'h00, 8'h00, 6'd20, 1, 20, 0, 20, 0);
      run_point(ONE, 8'h00, 6'd20, 1, 1, 1, 2, 0);
      run_point(neg_one, 8'h00, 6'd63, 1, 63, 0, 63, 0);
      run_point(MINUS_TWO, 8'h00, 6'd10, 1, 1, 1, 2, 0);
      run_point(ONE, ONE, 6'd0, 1, 0, 0, 0, 0);
      run_point(ONE, 8'h00, 6'd20, 1, 1, 1, 2, 10);
      run_point(8'h20, 8'h20, 6'd30, 1, 4, 1, 5, 0);

      // Reset in the middle of a long run.
      bus.in_cr = 8'h00;
      bus.in_ci = 8'h00;
      bus.in_max_iter = 6'd40;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrun_rst_in_ready", bus.in_ready, 1);
      check("midrun_rst_out_valid", bus.out_valid, 0);
      check("midrun_rst_out_iter", bus.out_iter, 0);
      check("midrun_rst_out_escaped", bus.out_escaped, 0);
      run_point(8'h20, 8'h20, 6'd30, 1, 4, 1, 5, 3);

      // A few arbitrary points, checked by the monitor only.
      for (int i = 0; i < 4; i++)
         run_point(8'($urandom), 8'($urandom), 6'($urandom_range(1, 63)), 0, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
